// File: rtl/v_axi4s_vid_out_pkg.sv
// Shared types and helpers for the AXI4-Stream to parallel video output bridge.
// FIFO entries are {tuser, tdata}; the state encoding is shared by RTL and debug tools.
package v_axi4s_vid_out_pkg;

  localparam int TDATA_W_DFLT = 16;

  typedef logic [1:0] state_t;
  localparam state_t S_SYNC   = 2'd0;
  localparam state_t S_WAIT   = 2'd1;
  localparam state_t S_LOCKED = 2'd2;

  function automatic int fifo_width(input int dw);
    return dw + 1;
  endfunction

  function automatic int tuser_bit(input int dw);
    return dw;
  endfunction

  localparam int FIFO_WIDTH = fifo_width(TDATA_W_DFLT);
  localparam int TUSER_BIT  = tuser_bit(TDATA_W_DFLT);

endpackage

// File: rtl/v_axi4s_vid_out_if.sv
// AXI4-Stream video beat bundle: tuser marks start of frame, tlast marks end of line.
interface v_axi4s_vid_out_if
  import v_axi4s_vid_out_pkg::*;
#(
  parameter int DW = TDATA_W_DFLT
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/v_axi4s_vid_out_fifo.sv
// First-word fall-through FIFO: head visible combinationally, writes refused when full.
// Latency: a write is visible at the head the cycle after it is accepted; all state holds when i_en is low.
module v_axi4s_vid_out_fifo
  import v_axi4s_vid_out_pkg::*;
#(
  parameter int DW = FIFO_WIDTH,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_wr_vld,
  input  logic [DW-1:0] i_wr_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_rd_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_wr;
  logic          w_rd;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign o_count  = r_wr_ptr - r_rd_ptr;
  assign o_full   = o_count[AW];
  assign o_empty  = (o_count == '0);
  assign o_rd_dat = r_mem[r_rd_ptr[AW-1:0]];

  assign w_wr = i_en & i_wr_vld & ~o_full;
  assign w_rd = i_en & i_pop & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
  end

endmodule

// File: rtl/v_axi4s_vid_out.sv
// AXI4-Stream video to parallel video: aligns stream frames (tuser) to external timing via a FWFT FIFO.
// Latency: timing outputs and popped pixels appear 1 cycle after the vtg cycle; tready = ~full.
module v_axi4s_vid_out
  import v_axi4s_vid_out_pkg::*;
#(
  parameter int C_S_AXIS_VIDEO_TDATA_WIDTH = TDATA_W_DFLT,
  parameter int VID_OUT_DATA_WIDTH         = TDATA_W_DFLT,
  parameter int FIFO_ADDR_BITS             = 10,
  parameter int HYSTERESIS_LEVEL           = 12
) (
  input  logic                          aclk,
  input  logic                          rst,
  input  logic                          i_aclken,
  v_axi4s_vid_out_if.slave              s_axis_video,
  input  logic                          i_vtg_active_video,
  input  logic                          i_vtg_vblank,
  input  logic                          i_vtg_hblank,
  input  logic                          i_vtg_vsync,
  input  logic                          i_vtg_hsync,
  output logic                          o_vid_de,
  output logic                          o_vid_vblank,
  output logic                          o_vid_hblank,
  output logic                          o_vid_vsync,
  output logic                          o_vid_hsync,
  output logic [VID_OUT_DATA_WIDTH-1:0] o_vid_data,
  output logic                          o_locked,
  output logic                          o_underflow,
  output logic                          o_fifo_empty
);
  localparam int FW = fifo_width(C_S_AXIS_VIDEO_TDATA_WIDTH);
  localparam int UB = tuser_bit(C_S_AXIS_VIDEO_TDATA_WIDTH);
  localparam logic [FIFO_ADDR_BITS:0] HYST_LVL = (FIFO_ADDR_BITS+1)'(HYSTERESIS_LEVEL);

  logic [FW-1:0]                 w_head;
  logic                          w_head_sof;
  logic [VID_OUT_DATA_WIDTH-1:0] w_head_dat;
  logic                          w_full;
  logic                          w_empty;
  logic [FIFO_ADDR_BITS:0]       w_count;
  logic                          w_pop;
  logic                          w_uflow;
  state_t                        w_state_nxt;
  logic [VID_OUT_DATA_WIDTH-1:0] w_vid_dat_nxt;
  logic                          w_unused_tlast;

  state_t                        r_state;
  logic                          r_sof_pending;
  logic                          r_vsync_d;
  logic [4:0]                    r_timing;
  logic [VID_OUT_DATA_WIDTH-1:0] r_vid_data;
  logic                          r_locked;
  logic                          r_underflow;

  v_axi4s_vid_out_fifo #(
    .DW (FW),
    .AW (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk      (aclk),
    .rst      (rst),
    .i_en     (i_aclken),
    .i_wr_vld (s_axis_video.tvalid),
    .i_wr_dat ({s_axis_video.tuser, s_axis_video.tdata}),
    .i_pop    (w_pop),
    .o_rd_dat (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  assign w_unused_tlast = s_axis_video.tlast;
  assign w_head_sof     = w_head[UB];
  assign w_head_dat     = w_head[UB-1:0];

  assign s_axis_video.tready = ~rst & ~w_full;
  assign o_fifo_empty        = ~rst & w_empty;

  assign {o_vid_de, o_vid_vblank, o_vid_hblank, o_vid_vsync, o_vid_hsync} = r_timing;
  assign o_vid_data  = r_vid_data;
  assign o_locked    = r_locked;
  assign o_underflow = r_underflow;

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_uflow       = 1'b0;
    w_vid_dat_nxt = '0;
    case (r_state)
      S_SYNC: begin
        if (!w_empty) begin
          if (w_head_sof) w_state_nxt = S_WAIT;
          else            w_pop       = 1'b1;
        end
      end
      S_WAIT: begin
        if ((w_count >= HYST_LVL) && r_sof_pending && i_vtg_active_video) begin
          w_pop         = 1'b1;
          w_state_nxt   = S_LOCKED;
          w_vid_dat_nxt = w_head_dat;
        end
      end
      S_LOCKED: begin
        if (i_vtg_active_video) begin
          if (w_empty) begin
            w_uflow     = 1'b1;
            w_state_nxt = S_SYNC;
          end else if (r_sof_pending != w_head_sof) begin
            // SOF missing on the first pixel, or arriving mid-frame: the stream is misaligned.
            w_state_nxt = S_SYNC;
          end else begin
            w_pop         = 1'b1;
            w_vid_dat_nxt = w_head_dat;
          end
        end
      end
      default: w_state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state       <= S_SYNC;
      r_sof_pending <= 1'b0;
      r_vsync_d     <= 1'b0;
      r_timing      <= '0;
      r_vid_data    <= '0;
      r_locked      <= 1'b0;
      r_underflow   <= 1'b0;
    end else if (i_aclken) begin
      r_state   <= w_state_nxt;
      r_vsync_d <= i_vtg_vsync;
      if (i_vtg_vsync && !r_vsync_d)
        r_sof_pending <= 1'b1;
      else if (i_vtg_active_video)
        r_sof_pending <= 1'b0;
      r_timing    <= {i_vtg_active_video, i_vtg_vblank, i_vtg_hblank, i_vtg_vsync, i_vtg_hsync};
      r_vid_data  <= w_vid_dat_nxt;
      r_locked    <= (w_state_nxt == S_LOCKED);
      r_underflow <= w_uflow;
    end
  end

endmodule

// File: doc/v_axi4s_vid_out.md
Name: v_axi4s_vid_out

Overview:
- Converts an AXI4-Stream video stream (tuser = start of frame, tlast = end of line) into parallel video with DE, blank and sync signals.
- Timing comes from an external video timing generator on the vtg_* inputs. The block aligns stream frames to that timing, buffers pixels in an internal FIFO, and reports lock and underflow.
- It is the output-side counterpart of the video-in bridge. It sits between the processing pipeline (for example, the sobel filter) and the display PHY.

Parameters:
- C_S_AXIS_VIDEO_TDATA_WIDTH, 16, stream data width in bits.
- VID_OUT_DATA_WIDTH, 16, video output data width. Must equal C_S_AXIS_VIDEO_TDATA_WIDTH.
- FIFO_ADDR_BITS, 10, FIFO depth is 2**FIFO_ADDR_BITS entries.
- HYSTERESIS_LEVEL, 12, minimum FIFO fill before lock is allowed.

Ports:
- aclk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- aclken  in  1  clock enable. When low, all state and outputs hold.
- s_axis_video_tdata  in  C_S_AXIS_VIDEO_TDATA_WIDTH  pixel data.
- s_axis_video_tvalid  in  1  stream valid.
- s_axis_video_tready  out  1  stream ready.
- s_axis_video_tuser  in  1  start of frame.
- s_axis_video_tlast  in  1  end of line. Accepted but not checked.
- vtg_active_video  in  1  timing active region.
- vtg_vblank, vtg_hblank, vtg_vsync, vtg_hsync  in  1 each  timing signals.
- vid_de, vid_vblank, vid_hblank, vid_vsync, vid_hsync  out  1 each  registered timing outputs.
- vid_data  out  VID_OUT_DATA_WIDTH  output pixel.
- locked  out  1  stream is aligned to the timing.
- underflow  out  1  one-cycle pulse on a FIFO underflow during active video.
- fifo_empty  out  1  FIFO empty status.

Behaviour:
- Reset: all outputs 0, except s_axis_video_tready, which is also 0 during reset. FSM = S_SYNC, FIFO flushed, sof_pending = 0.
- All logic below advances only when aclken = 1.
- Write side:
  - s_axis_video_tready = ~full, in every state.
  - A write occurs on tvalid & tready and stores {tuser, tdata}. tlast is dropped.
  - No write occurs when full, even if a pop happens in the same cycle.
- FIFO is first-word fall-through, so the head entry is visible combinationally.
- Timing path:
  - vid_de/vblank/hblank/vsync/hsync are the vtg_* inputs delayed by exactly 1 cycle, in every state.
  - vid_data is registered in the same cycle, so it aligns with vid_de.
- sof_pending:
  - Set on a rising edge of vtg_vsync, detected against a registered copy of vtg_vsync.
  - Cleared on the first cycle with vtg_active_video = 1.
  - If set and cleared in the same cycle, set wins.
- FSM states:
  - S_SYNC:
    - locked = 0, vid_data = 0.
    - If the FIFO is non-empty and head.tuser = 0, pop (discard) one entry per cycle.
    - If head.tuser = 1, hold the head and go to S_WAIT.
  - S_WAIT:
    - locked = 0, vid_data = 0, no pops.
    - Go to S_LOCKED when fill ≥ HYSTERESIS_LEVEL and sof_pending = 1 and vtg_active_video = 1.
    - In that transition cycle, pop the SOF pixel and drive it on vid_data.
  - S_LOCKED:
    - locked = 1.
    - Each cycle with vtg_active_video = 1 pops one entry, and vid_data = head.tdata.
    - When vtg_active_video = 0, vid_data = 0 and there is no pop.
  - Loss of lock (locked → 0 next cycle, go to S_SYNC, no pop in that cycle):
    - (a) active video with the FIFO empty. underflow pulses for 1 cycle and vid_data = 0.
    - (b) first active pixel of a frame (sof_pending = 1) with head.tuser = 0.
    - (c) head.tuser = 1 on a non-first active pixel. That SOF entry is kept as the new head.
- Latency: a stream pixel appears on vid_data 1 cycle after the vtg_active_video cycle that pops it.
- Reset mid-frame: immediate return to reset values. The FIFO contents are lost.

Decomposition:
- Shared package v_axi4s_vid_out_pkg holds:
  - the FSM state enum (S_SYNC, S_WAIT, S_LOCKED);
  - localparam FIFO_WIDTH = C_S_AXIS_VIDEO_TDATA_WIDTH + 1;
  - the tuser bit index.
- One sub-module, v_axi4s_vid_out_fifo:
  - synchronous, first-word fall-through, depth 2**FIFO_ADDR_BITS;
  - outputs full, empty and fill count (FIFO_ADDR_BITS+1 bits);
  - asynchronous active-high rst.

Test Plan:
- Lock: stream 4x2 frames, data = 0x0100 + index, with vtg at 8 clocks per line and a vsync pulse, HYSTERESIS_LEVEL = 4.
  → locked rises on the first active pixel of frame 1. vid_data shows 0x0100..0x0107 one cycle after each vtg_active_video, and vid_de matches vtg_active_video delayed by 1.
- Garbage before SOF: push 3 beats with tuser = 0, then a proper frame.
  → the 3 beats are discarded, and the first vid_data while locked = 1 is the tuser beat.
- Underflow: stop tvalid mid-line while locked.
  → underflow pulses once, locked falls the next cycle, vid_data = 0, and relock occurs at the next vsync with SOF.
- Early SOF: a tuser = 1 beat arrives at pixel 3 of a line.
  → locked falls, and that beat becomes the first pixel after relock.
- Backpressure: fill the FIFO to 1024 with no active video.
  → tready = 0 at full and no data is lost. After one pop, tready = 1.
- aclken = 0 for 5 cycles mid-line.
  → all outputs and the FIFO fill count hold. The sequence resumes unchanged.
